// File: rtl/dram_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_bank_responder
// Desc     : DDR4 x8 rank model (4 BG x 4 banks): per-bank row state, command
//            timing checks with coded violations, and the RD/WR data-bus window.
//            Optional statistics counters are built when RESP_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================

module dram_bank_responder #(
  parameter int TRCD   = 24,
  parameter int TRP    = 24,
  parameter int TRAS   = 52,
  parameter int TCL    = 24,
  parameter int TCWD   = 20,
  parameter int TBURST = 4,
  parameter int TWR    = 20,
  parameter int TRRD_S = 4,
  parameter int TRRD_L = 6,
  parameter int TCCD_S = 4,
  parameter int TCCD_L = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  input  logic [2:0]  cmd_op_i,
  input  logic [1:0]  cmd_bg_i,
  input  logic [1:0]  cmd_bank_i,
  input  logic [14:0] cmd_row_i,
  input  logic [10:0] cmd_col_i,
  output logic        viol_o,
  output logic [2:0]  viol_code_o,
  output logic [15:0] row_open_o,
  output logic        data_valid_o,
  output logic        data_is_wr_o,
  output logic [15:0] act_cnt_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  localparam int PIPE_D     = ((TCL > TCWD) ? TCL : TCWD) + TBURST;
  localparam int c_RD_START = TCL - 1;
  localparam int c_WR_START = TCWD - 1;

  localparam logic [2:0] c_OP_NOP = 3'd0;
  localparam logic [2:0] c_OP_ACT = 3'd1;
  localparam logic [2:0] c_OP_PRE = 3'd2;
  localparam logic [2:0] c_OP_RD  = 3'd3;
  localparam logic [2:0] c_OP_WR  = 3'd4;

  localparam logic [7:0] c_TRCD   = 8'(TRCD);
  localparam logic [7:0] c_TRP    = 8'(TRP);
  localparam logic [7:0] c_TRAS   = 8'(TRAS);
  localparam logic [7:0] c_TWR    = 8'(TWR);
  localparam logic [7:0] c_TRRD_S = 8'(TRRD_S);
  localparam logic [7:0] c_TRRD_L = 8'(TRRD_L);
  localparam logic [7:0] c_TCCD_S = 8'(TCCD_S);
  localparam logic [7:0] c_TCCD_L = 8'(TCCD_L);

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       last;
    logic [3:0] bank;
  } beat_t;

  // Timers hold cycles elapsed since their event; 255 means "long ago".
  logic [7:0]  bank_act_q  [16];
  logic [7:0]  bank_pre_q  [16];
  logic [7:0]  bank_wend_q [16];
  logic [7:0]  grp_act_q   [4];
  logic [7:0]  grp_rw_q    [4];
  logic [7:0]  glb_act_q;
  logic [7:0]  glb_rw_q;
  logic [15:0] row_open_q;
  logic        viol_q;
  logic [2:0]  viol_code_q;
  beat_t       pipe_q [PIPE_D];
  beat_t       pipe_d [PIPE_D];

  logic [3:0]  w_idx;
  logic        w_cmd, w_is_act, w_is_pre, w_is_rd, w_is_wr, w_is_rw;
  logic        w_collide, w_accept;
  logic [2:0]  w_code;
  int          w_start;

  // Row address and column are carried on the bus but play no part in checking.
  logic w_unused_cmd;
  assign w_unused_cmd = ^{cmd_row_i, cmd_col_i};

  function automatic logic [7:0] sat_inc(input logic [7:0] t);
    return (t == 8'hFF) ? t : t + 8'd1;
  endfunction

  always_comb begin
    w_idx     = {cmd_bg_i, cmd_bank_i};
    w_cmd     = cmd_valid_i && (cmd_op_i != c_OP_NOP);
    w_is_act  = (cmd_op_i == c_OP_ACT);
    w_is_pre  = (cmd_op_i == c_OP_PRE);
    w_is_rd   = (cmd_op_i == c_OP_RD);
    w_is_wr   = (cmd_op_i == c_OP_WR);
    w_is_rw   = w_is_rd || w_is_wr;
    w_start   = w_is_wr ? c_WR_START : c_RD_START;
    w_collide = 1'b0;

    for (int i = 0; i < PIPE_D - 1; i++) pipe_d[i] = pipe_q[i+1];
    pipe_d[PIPE_D-1] = '0;

    // Slot i of the shifted pipe is driven on the bus i+1 cycles from now.
    for (int i = 0; i < PIPE_D; i++) begin
      if (i >= w_start && i < w_start + TBURST && pipe_d[i].valid) w_collide = 1'b1;
    end

    w_code = 3'd0;
    if (w_cmd) begin
      if (cmd_op_i > c_OP_WR)                                   w_code = 3'd1;
      else if (w_is_act && row_open_q[w_idx])                   w_code = 3'd1;
      else if (w_is_rw && !row_open_q[w_idx])                   w_code = 3'd1;
      else if (w_is_act && bank_pre_q[w_idx] < c_TRP)           w_code = 3'd2;
      else if (w_is_act && (grp_act_q[cmd_bg_i] < c_TRRD_L ||
                            glb_act_q < c_TRRD_S))              w_code = 3'd3;
      else if (w_is_pre && bank_act_q[w_idx] < c_TRAS)          w_code = 3'd4;
      else if (w_is_pre && bank_wend_q[w_idx] < c_TWR)          w_code = 3'd5;
      else if (w_is_rw && bank_act_q[w_idx] < c_TRCD)           w_code = 3'd6;
      else if (w_is_rw && (grp_rw_q[cmd_bg_i] < c_TCCD_L ||
                           glb_rw_q < c_TCCD_S || w_collide))   w_code = 3'd7;
    end
    w_accept = w_cmd && (w_code == 3'd0);

    if (w_accept && w_is_rw) begin
      for (int i = 0; i < PIPE_D; i++) begin
        if (i >= w_start && i < w_start + TBURST) begin
          pipe_d[i].valid = 1'b1;
          pipe_d[i].wr    = w_is_wr;
          pipe_d[i].last  = (i == w_start + TBURST - 1);
          pipe_d[i].bank  = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 16; b++) begin
        bank_act_q[b]  <= 8'hFF;
        bank_pre_q[b]  <= 8'hFF;
        bank_wend_q[b] <= 8'hFF;
      end
      for (int g = 0; g < 4; g++) begin
        grp_act_q[g] <= 8'hFF;
        grp_rw_q[g]  <= 8'hFF;
      end
      glb_act_q   <= 8'hFF;
      glb_rw_q    <= 8'hFF;
      row_open_q  <= '0;
      viol_q      <= 1'b0;
      viol_code_q <= 3'd0;
      for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= '0;
    end else begin
      for (int b = 0; b < 16; b++) begin
        bank_act_q[b]  <= sat_inc(bank_act_q[b]);
        bank_pre_q[b]  <= sat_inc(bank_pre_q[b]);
        bank_wend_q[b] <= sat_inc(bank_wend_q[b]);
      end
      for (int g = 0; g < 4; g++) begin
        grp_act_q[g] <= sat_inc(grp_act_q[g]);
        grp_rw_q[g]  <= sat_inc(grp_rw_q[g]);
      end
      glb_act_q   <= sat_inc(glb_act_q);
      glb_rw_q    <= sat_inc(glb_rw_q);
      viol_q      <= (w_code != 3'd0);
      viol_code_q <= w_code;
      for (int i = 0; i < PIPE_D; i++) pipe_q[i] <= pipe_d[i];

      // Write recovery starts counting the cycle after the final write beat.
      if (pipe_q[0].valid && pipe_q[0].wr && pipe_q[0].last)
        bank_wend_q[pipe_q[0].bank] <= 8'd0;

      if (w_accept) begin
        if (w_is_act) begin
          row_open_q[w_idx]   <= 1'b1;
          bank_act_q[w_idx]   <= 8'd1;
          grp_act_q[cmd_bg_i] <= 8'd1;
          glb_act_q           <= 8'd1;
        end
        if (w_is_pre && row_open_q[w_idx]) begin
          row_open_q[w_idx] <= 1'b0;
          bank_pre_q[w_idx] <= 8'd1;
        end
        if (w_is_rw) begin
          grp_rw_q[cmd_bg_i] <= 8'd1;
          glb_rw_q           <= 8'd1;
        end
      end
    end
  end

  assign viol_o       = viol_q;
  assign viol_code_o  = viol_code_q;
  assign row_open_o   = row_open_q;
  assign data_valid_o = pipe_q[0].valid;
  assign data_is_wr_o = pipe_q[0].valid && pipe_q[0].wr;

`ifdef RESP_STATS_EN
  logic [15:0] act_cnt_q, rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_cnt_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else if (w_accept) begin
      if (w_is_act) act_cnt_q <= act_cnt_q + 16'd1;
      if (w_is_rd)  rd_cnt_q  <= rd_cnt_q + 16'd1;
      if (w_is_wr)  wr_cnt_q  <= wr_cnt_q + 16'd1;
    end
  end

  assign act_cnt_o = act_cnt_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
`else
  assign act_cnt_o = '0;
  assign rd_cnt_o  = '0;
  assign wr_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_bank_responder
// Desc     : Self-checking bench for dram_bank_responder using a timestamp-based
//            reference model of the rank (honours RESP_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================

module tb_dram_bank_responder;

  localparam int TRCD = 24, TRP = 24, TRAS = 52, TCL = 24, TCWD = 20, TBURST = 4;
  localparam int TWR = 20, TRRD_S = 4, TRRD_L = 6, TCCD_S = 4, TCCD_L = 8;
  localparam int NEVER = -100000;

  typedef logic [69:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_bg, cmd_bank;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        viol_o, data_valid_o, data_is_wr_o;
  logic [2:0]  viol_code_o;
  logic [15:0] row_open_o, act_cnt_o, rd_cnt_o, wr_cnt_o;

  always #5 clk = ~clk;

  dram_bank_responder dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_op_i     (cmd_op),
    .cmd_bg_i     (cmd_bg),
    .cmd_bank_i   (cmd_bank),
    .cmd_row_i    (cmd_row),
    .cmd_col_i    (cmd_col),
    .viol_o       (viol_o),
    .viol_code_o  (viol_code_o),
    .row_open_o   (row_open_o),
    .data_valid_o (data_valid_o),
    .data_is_wr_o (data_is_wr_o),
    .act_cnt_o    (act_cnt_o),
    .rd_cnt_o     (rd_cnt_o),
    .wr_cnt_o     (wr_cnt_o)
  );

  int checks = 0;
  int passes = 0;
  int now    = 0;

  // Reference model: event timestamps in absolute cycles.
  int          act_t [16];
  int          pre_t [16];
  int          gact  [4];
  int          grw   [4];
  logic [15:0] open_m;
  byte         beat_m [int];
  int          wend_t [$];
  int          wend_b [$];
  logic [15:0] m_act, m_rd, m_wr;

  function automatic int el(int t);
    int d;
    d = now - t;
    return (d > 255) ? 255 : d;
  endfunction

  function automatic int wend_el(int b);
    int best;
    best = NEVER;
    foreach (wend_t[i]) if (wend_b[i] == b && wend_t[i] <= now && wend_t[i] > best) best = wend_t[i];
    return el(best);
  endfunction

  function automatic void model_reset();
    for (int b = 0; b < 16; b++) begin act_t[b] = NEVER; pre_t[b] = NEVER; end
    for (int g = 0; g < 4; g++) begin gact[g] = NEVER; grw[g] = NEVER; end
    open_m = '0;
    beat_m.delete();
    wend_t.delete();
    wend_b.delete();
    m_act = '0; m_rd = '0; m_wr = '0;
  endfunction

  function automatic int rule(logic [2:0] op, int g, int b);
    bit rw;
    int lat;
    rw  = (op == 3'd3) || (op == 3'd4);
    lat = (op == 3'd4) ? TCWD : TCL;
    if (op > 3'd4) return 1;
    if (op == 3'd1 && open_m[b]) return 1;
    if (rw && !open_m[b]) return 1;
    if (op == 3'd1 && el(pre_t[b]) < TRP) return 2;
    if (op == 3'd1) begin
      if (el(gact[g]) < TRRD_L) return 3;
      for (int o = 0; o < 4; o++) if (o != g && el(gact[o]) < TRRD_S) return 3;
    end
    if (op == 3'd2 && el(act_t[b]) < TRAS) return 4;
    if (op == 3'd2 && wend_el(b) < TWR) return 5;
    if (rw && el(act_t[b]) < TRCD) return 6;
    if (rw) begin
      if (el(grw[g]) < TCCD_L) return 7;
      for (int o = 0; o < 4; o++) if (o != g && el(grw[o]) < TCCD_S) return 7;
      for (int k = 0; k < TBURST; k++) if (beat_m.exists(now + lat + k)) return 7;
    end
    return 0;
  endfunction

  function automatic void apply(logic [2:0] op, int g, int b);
    int lat;
    lat = (op == 3'd4) ? TCWD : TCL;
    if (op == 3'd1) begin
      open_m[b] = 1'b1; act_t[b] = now; gact[g] = now; m_act = m_act + 16'd1;
    end else if (op == 3'd2) begin
      if (open_m[b]) begin open_m[b] = 1'b0; pre_t[b] = now; end
    end else begin
      grw[g] = now;
      for (int k = 0; k < TBURST; k++) beat_m[now + lat + k] = (op == 3'd4) ? 8'sd2 : 8'sd1;
      if (op == 3'd4) begin
        wend_t.push_back(now + TCWD + TBURST); wend_b.push_back(b); m_wr = m_wr + 16'd1;
      end else m_rd = m_rd + 16'd1;
    end
  endfunction

  // Drives one cycle, advances the model, returns expected outputs after the edge.
  task automatic tick(input logic r, input logic v, input logic [2:0] op, input logic [1:0] g,
                      input logic [1:0] bk, input logic [14:0] row, output vec_t e);
    int code, b;
    logic dv, wr;
    logic [47:0] cnts;
    b = int'({g, bk});
    code = 0;
    rst = r; cmd_valid = v; cmd_op = op; cmd_bg = g; cmd_bank = bk; cmd_row = row;
    cmd_col = 11'($urandom);
    if (r) model_reset();
    else if (v && op != 3'd0) begin
      code = rule(op, int'(g), b);
      if (code == 0) apply(op, int'(g), b);
    end
    @(posedge clk);
    #1;
    now++;
    dv = beat_m.exists(now);
    wr = 1'b0;
    if (dv) wr = (beat_m[now] == 8'sd2);
`ifdef RESP_STATS_EN
    cnts = {m_act, m_rd, m_wr};
`else
    cnts = 48'd0;
`endif
    e = {code != 0, 3'(code), open_m, dv, wr, cnts};
  endtask

  function automatic vec_t dut_vec();
    return {viol_o, viol_code_o, row_open_o, data_valid_o, data_is_wr_o, act_cnt_o, rd_cnt_o, wr_cnt_o};
  endfunction

  task automatic do_reset;
    vec_t e;
    tick(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 15'd0, e);
  endtask

  task automatic test_reset;
    vec_t e;
    tick(1'b1, 1'b1, 3'd1, 2'd0, 2'd0, 15'h5, e);
    checks++; if (row_open_o !== 16'h0) $display("FAIL reset_row_open got %h want 0000", row_open_o); else passes++;
    checks++; if ({viol_o, viol_code_o, data_valid_o, data_is_wr_o} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {viol_o, viol_code_o, data_valid_o, data_is_wr_o}); else passes++;
    checks++; if ({act_cnt_o, rd_cnt_o, wr_cnt_o} !== 48'h0)
      $display("FAIL reset_counters got %h want 0", {act_cnt_o, rd_cnt_o, wr_cnt_o}); else passes++;
    tick(1'b0, 1'b1, 3'd1, 2'd1, 2'd1, 15'h7, e);
    checks++; if ({viol_o, row_open_o} !== {1'b0, 16'h0020})
      $display("FAIL first_act got viol=%b open=%h want viol=0 open=0020", viol_o, row_open_o); else passes++;
  endtask

  task automatic test_read_path;
    vec_t e; logic [2:0] op; int first, beats;
    first = -1; beats = 0;
    do_reset();
    for (int k = 0; k < 66; k++) begin
      op = (k == 10) ? 3'd1 : (k == 34) ? 3'd3 : 3'd0;
      tick(1'b0, op != 3'd0, op, 2'd0, 2'd0, 15'h12, e);
      checks++; if (dut_vec() !== e) $display("FAIL read_path k=%0d got %h want %h", k, dut_vec(), e); else passes++;
      if (data_valid_o === 1'b1) begin
        if (first < 0) first = k + 1;
        beats++;
      end
    end
    checks++; if (first !== 58 || beats !== 4)
      $display("FAIL read_window got first=%0d beats=%0d want first=58 beats=4", first, beats); else passes++;
  endtask

  task automatic test_trcd;
    vec_t e; logic [2:0] op; logic seen;
    seen = 1'b0;
    do_reset();
    for (int k = 0; k < 66; k++) begin
      op = (k == 10) ? 3'd1 : (k == 33 || k == 34) ? 3'd3 : 3'd0;
      tick(1'b0, op != 3'd0, op, 2'd1, 2'd2, 15'h3, e);
      checks++; if (dut_vec() !== e) $display("FAIL trcd k=%0d got %h want %h", k, dut_vec(), e); else passes++;
      if (k == 33) seen = viol_o && (viol_code_o == 3'd6);
    end
    checks++; if (seen !== 1'b1) $display("FAIL trcd_code got %b want 1", seen); else passes++;
  endtask

  task automatic test_trrd;
    vec_t e; logic [2:0] op; logic [1:0] g, bk;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      op = (k == 0 || k == 4 || k == 5) ? 3'd1 : 3'd0;
      g  = (k == 4) ? 2'd1 : 2'd0;
      bk = (k == 5) ? 2'd1 : 2'd0;
      tick(1'b0, op != 3'd0, op, g, bk, 15'h1, e);
      checks++; if (dut_vec() !== e) $display("FAIL trrd k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
  endtask

  task automatic test_write_twr;
    vec_t e; logic [2:0] op; int wbeats;
    wbeats = 0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      case (k)
        0, 91, 92: op = 3'd1;
        24:        op = 3'd4;
        60, 68:    op = 3'd2;
        default:   op = 3'd0;
      endcase
      tick(1'b0, op != 3'd0, op, 2'd0, 2'd0, 15'h44, e);
      checks++; if (dut_vec() !== e) $display("FAIL write_twr k=%0d got %h want %h", k, dut_vec(), e); else passes++;
      if (k >= 43 && k <= 46 && data_valid_o === 1'b1 && data_is_wr_o === 1'b1) wbeats++;
    end
    checks++; if (wbeats !== 4) $display("FAIL write_window got %0d want 4", wbeats); else passes++;
  endtask

  task automatic test_bank_state;
    vec_t e; logic [2:0] op; logic [1:0] g, bk; logic v;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      v = 1'b1; g = 2'd2; bk = 2'd3;
      case (k)
        0:       op = 3'd3;
        1, 8:    op = 3'd1;
        9:       begin op = 3'd2; g = 2'd3; end
        10:      op = 3'd6;
        11:      begin op = 3'd1; v = 1'b0; g = 2'd0; bk = 2'd0; end
        default: begin op = 3'd0; v = 1'b0; end
      endcase
      tick(1'b0, v, op, g, bk, 15'h9, e);
      checks++; if (dut_vec() !== e) $display("FAIL bank_state k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
  endtask

  task automatic test_collision;
    vec_t e; logic [2:0] op; logic [1:0] g;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      g = 2'd0;
      case (k)
        0:       op = 3'd1;
        6:       begin op = 3'd1; g = 2'd1; end
        30:      op = 3'd3;
        34, 38:  begin op = 3'd4; g = 2'd1; end
        default: op = 3'd0;
      endcase
      tick(1'b0, op != 3'd0, op, g, 2'd0, 15'h2, e);
      checks++; if (dut_vec() !== e) $display("FAIL collision k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
  endtask

  task automatic test_reset_midburst;
    vec_t e; logic [2:0] op;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      op = (k == 0) ? 3'd1 : (k == 24) ? 3'd4 : 3'd0;
      tick(1'b0, op != 3'd0, op, 2'd0, 2'd0, 15'h6, e);
      checks++; if (dut_vec() !== e) $display("FAIL midburst k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
    checks++; if (data_valid_o !== 1'b1) $display("FAIL midburst_beat2 got %b want 1", data_valid_o); else passes++;
    tick(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 15'h0, e);
    checks++; if ({data_valid_o, row_open_o} !== 17'h0)
      $display("FAIL midburst_flush got dv=%b open=%h want dv=0 open=0000", data_valid_o, row_open_o); else passes++;
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 15'h0, e);
      checks++; if (dut_vec() !== e) $display("FAIL midburst_after k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
  endtask

  task automatic test_stats;
    vec_t e; logic [2:0] op; logic [1:0] g; logic [31:0] want;
    do_reset();
    for (int k = 0; k < 45; k++) begin
      case (k)
        0:       begin op = 3'd1; g = 2'd0; end
        6:       begin op = 3'd1; g = 2'd1; end
        12:      begin op = 3'd1; g = 2'd2; end
        30:      begin op = 3'd3; g = 2'd0; end
        38:      begin op = 3'd3; g = 2'd1; end
        default: begin op = 3'd0; g = 2'd0; end
      endcase
      tick(1'b0, op != 3'd0, op, g, 2'd0, 15'h8, e);
      checks++; if (dut_vec() !== e) $display("FAIL stats k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
`ifdef RESP_STATS_EN
    want = {16'd3, 16'd2};
`else
    want = 32'd0;
`endif
    checks++; if ({act_cnt_o, rd_cnt_o} !== want)
      $display("FAIL stats_counts got %h want %h", {act_cnt_o, rd_cnt_o}, want); else passes++;
    tick(1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 15'h0, e);
    checks++; if ({act_cnt_o, rd_cnt_o, wr_cnt_o} !== 48'h0)
      $display("FAIL stats_clear got %h want 0", {act_cnt_o, rd_cnt_o, wr_cnt_o}); else passes++;
  endtask

  task automatic test_random;
    vec_t e; logic [2:0] op; logic r, v; int sel;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(0, 999) == 0);
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 99);
      if (sel < 30)      op = 3'd1;
      else if (sel < 50) op = 3'd2;
      else if (sel < 70) op = 3'd3;
      else if (sel < 90) op = 3'd4;
      else if (sel < 95) op = 3'($urandom_range(5, 7));
      else               op = 3'd0;
      tick(r, v, op, 2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 15'($urandom), e);
      checks++; if (dut_vec() !== e) $display("FAIL random k=%0d got %h want %h", k, dut_vec(), e); else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_bg = 2'd0; cmd_bank = 2'd0;
    cmd_row = 15'd0; cmd_col = 11'd0;
    do_reset();
    test_reset();
    test_read_path();
    test_trcd();
    test_trrd();
    test_write_twr();
    test_bank_state();
    test_collision();
    test_reset_midburst();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
